inst_fetch_queue: RTL

Instruction-fetch front end feeding the ID stage of the five-stage MIPS pipeline. It owns the PC and drives the SRAM-like instruction memory port with split request/response handshakes, supporting up to two in-flight requests. It buffers returned words with their PCs in a 2-entry queue and delivers them to ID over a valid/ready handshake. It applies ID's branch redirect (`br_e`, `br_addr`), preserving exactly one delay-slot instruction.

---
 rtl/inst_fetch_queue.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch front end for the ID stage.
// Owns the PC, issues up to two SRAM fetches and queues words for ID.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   br_bus[32:0]       {br_e, br_addr} redirect pulse from ID
//   inst_sram_*        split req/addr_ok and data_ok/rdata memory port
//   if_to_id_*         valid/ready delivery of {pc, inst} to ID
module inst_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [32:0] br_bus,
   output logic        inst_sram_req,
   output logic [31:0] inst_sram_addr,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
   output logic        if_to_id_valid,
   input  logic        if_to_id_ready,
   output logic [31:0] if_to_id_pc,
   output logic [31:0] if_to_id_inst
);

   typedef struct packed {
      logic        v;
      logic        disc;
      logic [31:0] pc;
   } fl_t;

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [31:0] inst;
   } qe_t;

   // Both FIFOs are 2-deep shift registers: entry 0 is the oldest.
   fl_t [1:0]   fl_q, fl_n;
   qe_t [1:0]   q_q, q_n;
   logic [31:0] pc_q, pc_n;
   logic [31:0] tgt_q, tgt_n;
   logic        pend_q, pend_n;
   logic        pdisc_q, pdisc_n;

   logic        br_e;
   logic [31:0] br_addr;
   logic [2:0]  occ;
   logic        acc, held, pop;
   logic        resp_keep;
   logic [31:0] resp_pc;
   logic        found;
   fl_t         new_fl;

   assign br_e    = br_bus[32];
   assign br_addr = br_bus[31:0];

   // Occupancy counts every queued word and every in-flight slot,
   // including ones already marked for discard.
   assign occ = 3'(q_q[0].v) + 3'(q_q[1].v)
              + 3'(fl_q[0].v) + 3'(fl_q[1].v);

   assign inst_sram_req  = resetn & (occ < 3'd2);
   assign inst_sram_addr = pc_q;

   assign if_to_id_valid = q_q[0].v;
   assign if_to_id_pc    = q_q[0].pc;
   assign if_to_id_inst  = q_q[0].inst;

   assign acc  = inst_sram_req & inst_sram_addr_ok;
   assign held = inst_sram_req & ~inst_sram_addr_ok;
   assign pop  = q_q[0].v & if_to_id_ready;

   always_comb begin
      fl_n      = fl_q;
      q_n       = q_q;
      pc_n      = pc_q;
      tgt_n     = tgt_q;
      pend_n    = pend_q;
      pdisc_n   = pdisc_q;
      resp_keep = 1'b0;
      resp_pc   = fl_q[0].pc;
      found     = 1'b0;
      new_fl    = '0;

      if (pop) begin
         q_n[0] = q_n[1];
         q_n[1] = '0;
      end

      if (inst_sram_data_ok) begin
         resp_keep = fl_q[0].v & ~fl_q[0].disc;
         fl_n[0]   = fl_n[1];
         fl_n[1]   = '0;
      end

      // The accepted request is the youngest entry this cycle.
      if (acc) begin
         new_fl.v    = 1'b1;
         new_fl.disc = pend_q & pdisc_q;
         new_fl.pc   = pc_q;
         if (!fl_n[0].v) fl_n[0] = new_fl;
         else            fl_n[1] = new_fl;
         pc_n    = pend_q ? tgt_q : pc_q + 32'd4;
         pend_n  = 1'b0;
         pdisc_n = 1'b0;
      end

      if (resp_keep) begin
         if (!q_n[0].v) q_n[0] = {1'b1, resp_pc, inst_sram_rdata};
         else           q_n[1] = {1'b1, resp_pc, inst_sram_rdata};
      end

      // Keep the oldest live instruction (delay slot), kill the rest.
      if (br_e && !pend_q) begin
         for (int i = 0; i < 2; i++) begin
            if (q_n[i].v) begin
               if (found) q_n[i] = '0;
               else       found  = 1'b1;
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (fl_n[i].v && !fl_n[i].disc) begin
               if (found) fl_n[i].disc = 1'b1;
               else       found        = 1'b1;
            end
         end
         // A held request cannot change address, so the target is
         // parked until it is accepted.
         if (held) begin
            pend_n  = 1'b1;
            tgt_n   = br_addr;
            pdisc_n = found;
         end else if (found) begin
            pc_n = br_addr;
         end else begin
            pend_n  = 1'b1;
            tgt_n   = br_addr;
            pdisc_n = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fl_q    <= '0;
         q_q     <= '0;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         pend_q  <= 1'b0;
         pdisc_q <= 1'b0;
      end else begin
         fl_q    <= fl_n;
         q_q     <= q_n;
         pc_q    <= pc_n;
         tgt_q   <= tgt_n;
         pend_q  <= pend_n;
         pdisc_q <= pdisc_n;
      end
   end

endmodule
